comp_sched: RTL and testbench

Round-robin scheduler that shares one unsigned magnitude comparator among `N_REQ` requesters in the ALU. Each requester presents an operand pair with a valid/ready handshake. The block grants one requester at a time, latches its operands, and performs the compare. It then returns equal/greater/less flags tagged with the requester index over a response handshake, so several ALU units can share one compare resource.

---
 rtl/comp_sched.sv | 116 +++++++++++
 tb/tb_comp_sched.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/comp_sched.sv
// comp_sched: round-robin arbiter in front of one shared unsigned comparator.
// One request in flight at a time; result is held until the consumer takes it.
module comp_sched #(
  parameter int WIDTH = 8,
  parameter int N_REQ = 4,
  parameter int IDW   = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [IDW-1:0]         rsp_id,
  output logic                   rsp_e,
  output logic                   rsp_g,
  output logic                   rsp_l,
  output logic                   busy,
  output logic [15:0]            done_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    CMP,
    RESP
  } state_t;

  state_t           state;
  state_t           nxt;
  logic [IDW-1:0]   last;
  logic [IDW-1:0]   win;
  logic             hit;
  logic [WIDTH-1:0] a_sel;
  logic [WIDTH-1:0] b_sel;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [15:0]      cnt_q;

  // Lowest valid index above last wins; otherwise wrap to lowest overall.
  always_comb begin
    hit = 1'b0;
    win = last;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_valid[i] && i <= int'(last)) begin
        hit = 1'b1;
        win = IDW'(i);
      end
    end
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_valid[i] && i > int'(last)) begin
        hit = 1'b1;
        win = IDW'(i);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    a_sel     = '0;
    b_sel     = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win == IDW'(i)) begin
        a_sel        = req_a[i*WIDTH +: WIDTH];
        b_sel        = req_b[i*WIDTH +: WIDTH];
        req_ready[i] = (state == IDLE) && hit;
      end
    end
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (hit) nxt = CMP;
      CMP:     nxt = RESP;
      RESP:    if (rsp_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      last   <= IDW'(N_REQ - 1);
      a_q    <= '0;
      b_q    <= '0;
      rsp_id <= '0;
      rsp_e  <= 1'b0;
      rsp_g  <= 1'b0;
      rsp_l  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      state <= nxt;
      if (state == IDLE && hit) begin
        a_q    <= a_sel;
        b_q    <= b_sel;
        rsp_id <= win;
        last   <= win;
      end
      if (state == CMP) begin
        rsp_e <= (a_q == b_q);
        rsp_g <= (a_q > b_q);
        rsp_l <= (a_q < b_q);
      end
      if (state == RESP && rsp_ready) begin
        cnt_q <= cnt_q + 16'd1;
      end
    end
  end

  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);
  assign done_cnt  = cnt_q;

endmodule

// File: tb/tb_comp_sched.sv
// tb_comp_sched: directed vectors against hand-computed compare results,
// grant order, backpressure, mid-op reset and done counter wrap.
module tb_comp_sched;
  localparam int W  = 8;
  localparam int N  = 4;
  localparam int IW = 2;
  localparam int FE = 4;
  localparam int FG = 2;
  localparam int FL = 1;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N*W-1:0] req_a = '0;
  logic [N*W-1:0] req_b = '0;
  logic [N-1:0]   req_ready;
  logic           rsp_valid;
  logic           rsp_ready = 1'b0;
  logic [IW-1:0]  rsp_id;
  logic           rsp_e;
  logic           rsp_g;
  logic           rsp_l;
  logic           busy;
  logic [15:0]    done_cnt;

  int          vecs = 0;
  int          errs = 0;
  logic [15:0] exp_done = '0;

  comp_sched #(.WIDTH(W), .N_REQ(N), .IDW(IW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_e(rsp_e), .rsp_g(rsp_g), .rsp_l(rsp_l),
    .busy(busy), .done_cnt(done_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] flags();
    return 32'({rsp_e, rsp_g, rsp_l});
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    chk("rst_valid", 32'(rsp_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done_cnt), 0);
    chk("rst_id", 32'(rsp_id), 0);
    chk("rst_flags", flags(), 0);
    chk("rst_ready", 32'(req_ready), 0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_done = '0;
  endtask

  task automatic run_one(input int r, input logic [7:0] a,
                         input logic [7:0] b, input int f,
                         input string tag);
    int n;
    @(negedge clk);
    req_a[r*W +: W] = a;
    req_b[r*W +: W] = b;
    req_valid[r]    = 1'b1;
    rsp_ready       = 1'b1;
    #1;
    n = 0;
    while (req_ready == '0 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk({tag, "_gnt"}, 32'(req_ready), 32'(1 << r));
    @(negedge clk);
    req_valid[r] = 1'b0;
    #1;
    chk({tag, "_cmp_valid"}, 32'(rsp_valid), 0);
    chk({tag, "_cmp_busy"}, 32'(busy), 1);
    @(negedge clk);
    #1;
    chk({tag, "_valid"}, 32'(rsp_valid), 1);
    chk({tag, "_id"}, 32'(rsp_id), 32'(r));
    chk({tag, "_flags"}, flags(), 32'(f));
    @(negedge clk);
    #1;
    exp_done = exp_done + 16'd1;
    chk({tag, "_done"}, 32'(done_cnt), 32'(exp_done));
    chk({tag, "_idle"}, 32'(busy), 0);
  endtask

  initial begin
    int k;
    int last_t;
    int exp_ids[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    logic [31:0] held;

    repeat (2) @(negedge clk);
    do_reset();

    run_one(0, 8'h1C, 8'h14, FG, "first");
    run_one(1, 8'h9C, 8'h14, FG, "c9c");
    run_one(2, 8'h1C, 8'h1C, FE, "ceq");
    run_one(3, 8'h04, 8'h14, FL, "c04");
    run_one(0, 8'hDC, 8'hD4, FG, "cdc");
    run_one(1, 8'h00, 8'hFF, FL, "cff");

    // all four requesting continuously
    do_reset();
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = 8'(i);
      req_b[i*W +: W] = 8'd1;
    end
    req_valid = '1;
    rsp_ready = 1'b1;
    k = 0;
    last_t = 0;
    for (int c = 0; c < 40 && k < 8; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      chk("rr_onehot", 32'($onehot0(req_ready)), 1);
      if (rsp_valid) begin
        chk("rr_id", 32'(rsp_id), 32'(exp_ids[k]));
        if (k > 0) chk("rr_gap", 32'(c - last_t), 3);
        last_t = c;
        k++;
        if (k == 8) req_valid = '0;
      end
    end
    chk("rr_count", 32'(k), 8);
    exp_done = exp_done + 16'd8;
    @(negedge clk);
    #1;
    chk("rr_done", 32'(done_cnt), 32'(exp_done));

    // backpressure with req 2 waiting
    @(negedge clk);
    req_a[1*W +: W] = 8'h30;
    req_b[1*W +: W] = 8'h40;
    req_valid[1]    = 1'b1;
    rsp_ready       = 1'b0;
    #1;
    chk("bp_gnt1", 32'(req_ready), 2);
    @(negedge clk);
    req_valid[1]    = 1'b0;
    req_a[2*W +: W] = 8'h55;
    req_b[2*W +: W] = 8'h55;
    req_valid[2]    = 1'b1;
    #1;
    chk("bp_cmp_ready", 32'(req_ready), 0);
    held = '0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      chk("bp_valid", 32'(rsp_valid), 1);
      chk("bp_flags", flags(), FL);
      chk("bp_id", 32'(rsp_id), 1);
      chk("bp_ready", 32'(req_ready), 0);
      chk("bp_busy", 32'(busy), 1);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    #1;
    exp_done = exp_done + 16'd1;
    chk("bp_gnt2", 32'(req_ready), 4);
    chk("bp_done", 32'(done_cnt), 32'(exp_done));
    @(negedge clk);
    req_valid[2] = 1'b0;
    @(negedge clk);
    #1;
    chk("bp2_id", 32'(rsp_id), 2);
    chk("bp2_flags", flags(), FE);
    @(negedge clk);
    #1;
    exp_done = exp_done + 16'd1;
    chk("bp2_done", 32'(done_cnt), 32'(exp_done));

    // reset while in CMP
    @(negedge clk);
    req_a[3*W +: W] = 8'h01;
    req_b[3*W +: W] = 8'h02;
    req_valid[3]    = 1'b1;
    #1;
    chk("mr_gnt", 32'(req_ready), 8);
    @(negedge clk);
    req_valid[3] = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mr_valid", 32'(rsp_valid), 0);
    chk("mr_busy", 32'(busy), 0);
    chk("mr_done", 32'(done_cnt), 0);
    req_a[1*W +: W] = 8'h77;
    req_b[1*W +: W] = 8'h07;
    req_valid = 4'b1010;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("mr_first", 32'(req_ready), 2);
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    #1;
    chk("mr_id", 32'(rsp_id), 1);
    chk("mr_flags", flags(), FG);
    @(negedge clk);
    #1;
    exp_done = 16'd1;
    chk("mr_done1", 32'(done_cnt), 32'(exp_done));

    // done counter wrap
    @(negedge clk);
    force dut.cnt_q = 16'hFFFE;
    #1;
    release dut.cnt_q;
    #1;
    exp_done = 16'hFFFE;
    chk("wrap_pre", 32'(done_cnt), 32'(exp_done));
    run_one(2, 8'hA0, 8'hA1, FL, "wrap1");
    run_one(3, 8'hFF, 8'h00, FG, "wrap2");
    chk("wrap_zero", 32'(done_cnt), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
